ama_riscv_imem_loader: RTL and testbench

- Writer side of the IMEM dual-port memory. The core only reads IMEM on port B; this block owns port A (ena/wea/addra/dina).
- It receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Words are written sequentially from address 0, and an XOR checksum is verified at the end.
- The core is held in reset for the whole load, then released with pc restarting at 0.

---
 rtl/ama_riscv_imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_ama_riscv_imem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_imem_loader.sv
// ama_riscv_imem_loader
//   Owns write port A of the IMEM. Receives a program image as a byte
//   stream (LEN_LO, LEN_HI, 4*N data bytes LSB first, XOR checksum byte),
//   packs little-endian 32-bit words and writes them from address 0 up.
//   The core is held in reset for the duration of a load.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   load_start        begin a load (only from IDLE or ERR)
//   load_abort        cancel a load in progress (-> ERR)
//   in_valid/in_data  byte stream, consumed when in_valid & in_ready
//   in_ready          loader can take a byte this cycle
//   imem_ena/wea/addra/dina  IMEM port A write interface
//   core_rst          reset to the core (rst or loader busy)
//   load_done         one-cycle pulse on a good load
//   load_err          sticky error, cleared by the next load_start
module ama_riscv_imem_loader #(
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_ena,
    output logic [3:0]        imem_wea,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dina,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_e;

    // 17 bits so the count can represent N == 2**16 limits without wrapping
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [16:0]       wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [31:0]       dina_q, dina_d;
    logic              err_q, err_d;

    logic busy, rx_state, hs;
    logic [15:0] n_len;

    assign busy     = (state_q != S_IDLE) && (state_q != S_ERR);
    assign rx_state = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);

    // Abort and reset both win over a byte on the same cycle, so ready is
    // withdrawn to keep the handshake meaning "byte consumed".
    assign in_ready   = rx_state & ~load_abort & ~rst;
    assign hs         = in_valid & in_ready;
    assign imem_ena   = (state_q == S_WRITE) & ~rst;
    assign imem_wea   = {4{imem_ena}};
    assign imem_addra = addra_q;
    assign imem_dina  = dina_q;
    assign core_rst   = rst | busy;
    assign load_done  = (state_q == S_DONE) & ~rst;
    assign load_err   = err_q;

    assign n_len = {in_data, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        waddr_d = waddr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        csum_d  = csum_q;
        addra_d = addra_q;
        dina_d  = dina_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (load_start) begin
                    state_d = S_LEN_LO;
                    waddr_d = '0;
                    wcnt_d  = '0;
                    idx_d   = '0;
                    csum_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (hs) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (hs) begin
                    len_d[15:8] = in_data;
                    if (n_len == 16'd0) begin
                        state_d = S_CSUM;
                    end else if ({1'b0, n_len} > MAX_N) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (hs) begin
                    word_d[8*idx_q +: 8] = in_data;
                    csum_d               = csum_q ^ in_data;
                    idx_d                = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Latch the completed word so port A holds it
                        // through WRITE and afterwards.
                        addra_d = waddr_q;
                        dina_d  = word_d;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                waddr_d = waddr_q + ADDR_W'(1);
                wcnt_d  = wcnt_q + 17'd1;
                state_d = (wcnt_d == {1'b0, len_q}) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (hs) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A WRITE in the abort cycle has already driven port A; only the
        // state change is overridden here.
        if (load_abort && busy) begin
            state_d = S_ERR;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            waddr_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            addra_q <= '0;
            dina_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            waddr_q <= waddr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ama_riscv_imem_loader.sv
module tb_ama_riscv_imem_loader;

  localparam int ADDR_W    = 14;
  localparam int MAX_WORDS = 16384;

  logic              clk = 1'b0;
  logic              rst, load_start, load_abort, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, imem_ena, core_rst, load_done, load_err;
  logic [3:0]        imem_wea;
  logic [ADDR_W-1:0] imem_addra;
  logic [31:0]       imem_dina;

  ama_riscv_imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_ena(imem_ena), .imem_wea(imem_wea), .imem_addra(imem_addra),
    .imem_dina(imem_dina), .core_rst(core_rst), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // write monitor
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt = 0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (imem_ena) begin
      wa_q.push_back(32'(imem_addra));
      wd_q.push_back(imem_dina);
      chk("wr_in_ready", 32'(in_ready), 32'd0);
      chk("wr_wea", 32'(imem_wea), 32'hF);
    end
    if (load_done) begin
      done_cnt++;
      chk("done_core_rst", 32'(core_rst), 32'd1);
    end
    if (done_prev) chk("core_rst_after_done", 32'(core_rst), 32'd0);
    done_prev = load_done;
  end

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was consumed.
  task automatic send(input logic [7:0] b, input int vpct);
    int guard = 0;
    in_data = b;
    forever begin
      in_valid = ($urandom_range(0, 99) < vpct);
      @(negedge clk);
      if (in_valid && in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 300) begin
        chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    chk("start_clears_err", 32'(load_err), 32'd0);
    @(posedge clk); #1;
  endtask

  // Reference: full load of `words` with declared length nlen. The checksum
  // byte is the XOR of the data bytes unless use_csum forces csum_val.
  task automatic run_load(input string tag, input logic [31:0] words[$], input int nlen,
                          input bit use_csum, input logic [7:0] csum_val, input int vpct);
    logic [7:0] x;
    logic [7:0] cs;
    bit         len_ok, good;
    int         wexp;
    clear_mon();
    pulse_start();
    send(8'(nlen), vpct);
    send(8'(nlen >> 8), vpct);
    len_ok = (nlen <= MAX_WORDS);
    x = 8'h00;
    if (len_ok) begin
      foreach (words[i])
        for (int k = 0; k < 4; k++) begin
          send(words[i][8*k +: 8], vpct);
          x = x ^ words[i][8*k +: 8];
        end
      cs = use_csum ? csum_val : x;
      send(cs, vpct);
    end
    good = len_ok && (cs == x);
    wexp = len_ok ? words.size() : 0;
    repeat (3) @(negedge clk);
    chk({tag, "_err"}, 32'(load_err), 32'(!good));
    chk({tag, "_done"}, 32'(done_cnt), 32'(good));
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(wexp));
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    if (wa_q.size() == wexp)
      for (int i = 0; i < wexp; i++) begin
        chk({tag, "_addr"}, wa_q[i], 32'(i));
        chk({tag, "_data"}, wd_q[i], words[i]);
      end
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w[$];
    logic [31:0] e[$];
    int n;
    rst = 1'b1; load_start = 1'b0; load_abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ena", 32'(imem_ena), 32'd0);
    chk("rst_wea", 32'(imem_wea), 32'd0);
    chk("rst_addra", 32'(imem_addra), 32'd0);
    chk("rst_dina", imem_dina, 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_core_rst", 32'(core_rst), 32'd0);
    @(posedge clk); #1;

    // directed two-word image, good and bad checksum
    w = '{32'h0000_0013, 32'h0010_0093};
    run_load("img_ok", w, 2, 1'b0, 8'h00, 100);
    run_load("img_bad", w, 2, 1'b1, 8'h00, 100);

    // oversize length: ERR right after LEN_HI, nothing written
    w.delete();
    run_load("too_long", w, 16641, 1'b0, 8'h00, 100);

    // empty image
    run_load("empty_ok", w, 0, 1'b1, 8'h00, 100);
    run_load("empty_bad", w, 0, 1'b1, 8'h5A, 100);

    // random 3-word loads with a stuttering stream, then random lengths
    for (int t = 0; t < 4; t++) begin
      w.delete();
      for (int i = 0; i < 3; i++) w.push_back($urandom());
      run_load("rnd3", w, 3, 1'b0, 8'h00, 50);
    end
    for (int t = 0; t < 4; t++) begin
      w.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) w.push_back($urandom());
      run_load("rndn", w, n, (t == 3), 8'($urandom()), 60);
    end

    // abort after two data bytes, with a byte on offer in the abort cycle
    clear_mon();
    pulse_start();
    send(8'h01, 100); send(8'h00, 100); send(8'hAA, 100); send(8'hBB, 100);
    in_valid = 1'b1; in_data = 8'hCC; load_abort = 1'b1;
    @(posedge clk); #1;
    load_abort = 1'b0;
    @(negedge clk);
    chk("abort_err", 32'(load_err), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_nwr", 32'(wa_q.size()), 32'd0);
    chk("abort_core_rst", 32'(core_rst), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of the second word
    clear_mon();
    e = '{32'h8765_4321};
    pulse_start();
    send(8'h02, 100); send(8'h00, 100);
    send(8'h21, 100); send(8'h43, 100); send(8'h65, 100); send(8'h87, 100);
    send(8'h11, 100);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h22;
    @(negedge clk);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_ena", 32'(imem_ena), 32'd0);
    chk("mrst_core_rst", 32'(core_rst), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_in_ready2", 32'(in_ready), 32'd0);
    chk("mrst_core_rst2", 32'(core_rst), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_core_rst", 32'(core_rst), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd0);
    chk("post_rst_err", 32'(load_err), 32'd0);
    chk("mrst_nwr", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      chk("mrst_addr", wa_q[0], 32'd0);
      chk("mrst_data", wd_q[0], e[0]);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // clean load after the reset
    w.delete();
    for (int i = 0; i < 2; i++) w.push_back($urandom());
    run_load("after_rst", w, 2, 1'b0, 8'h00, 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
